// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the RV32M multiply/divide unit.
//   - funct3_e : RV32M operation encodings
//   - state_e  : control FSM state encoding
//   - DIV_ITERATIONS : number of restoring-division steps
package mdu_pkg;

  localparam int DIV_ITERATIONS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: unsigned restoring radix-2 divider, one quotient bit per cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : load dividend/divisor and begin (ignored while busy)
//   abort               : synchronously drop the operation in flight
//   dividend, divisor   : 32-bit unsigned magnitudes
//   busy                : iterations in progress
//   last                : the current cycle performs the final iteration
//   done                : one-cycle pulse, quotient/remainder valid
//   quotient, remainder : 32-bit results
module mdu_divider
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        last,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic [31:0] dvsr_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        done_q;

  // Quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder while new quotient bits enter at the LSB.
  logic [32:0] partial;
  logic [32:0] diff;

  assign partial = {rem_q, quot_q[31]};
  assign diff    = partial - {1'b0, dvsr_q};

  assign busy      = busy_q;
  assign last      = busy_q & (count_q == 5'(DIV_ITERATIONS - 1));
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

  // Iteration state: load on start, one restoring step per busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_q  <= 32'd0;
      rem_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      count_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      count_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        quot_q  <= dividend;
        rem_q   <= 32'd0;
        dvsr_q  <= divisor;
        count_q <= 5'd0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        // Negative difference means the divisor did not fit: restore.
        if (diff[32]) begin
          rem_q  <= partial[31:0];
          quot_q <= {quot_q[30:0], 1'b0};
        end else begin
          rem_q  <= diff[31:0];
          quot_q <= {quot_q[30:0], 1'b1};
        end
        count_q <= count_q + 5'd1;
        if (last) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M multiply/divide unit with start/busy/done handshake.
// Multiplies finish in 2 cycles from the start cycle; divides take 34,
// except divide-by-zero and signed overflow which finish in 2.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   start, funct3         : request and RV32M operation select
//   operand_a, operand_b  : rs1, rs2 values
//   rd_in                 : destination register tag
//   flush                 : synchronous abort of any in-flight operation
//   busy                  : operation in flight (state != IDLE)
//   done                  : one-cycle pulse, result/rd_out valid
//   result, rd_out        : registered result and destination tag
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  state_e      state;
  funct3_e     op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic        quo_neg_q;
  logic        rem_neg_q;

  // ---------------- acceptance and operand conditioning ----------------
  logic        accept;
  logic        signed_div;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        fast_in;
  logic        div_start;

  assign accept     = start & ~flush & (state == IDLE);
  assign signed_div = ~funct3[0];
  assign a_neg_in   = signed_div & operand_a[31];
  assign b_neg_in   = signed_div & operand_b[31];
  assign a_mag      = a_neg_in ? (32'd0 - operand_a) : operand_a;
  assign b_mag      = b_neg_in ? (32'd0 - operand_b) : operand_b;
  // Divide-by-zero and signed overflow bypass the iterative divider.
  assign fast_in    = funct3[2] &
                      ((operand_b == 32'd0) |
                       (signed_div & (operand_a == 32'h8000_0000) &
                        (operand_b == 32'hFFFF_FFFF)));
  assign div_start  = accept & funct3[2] & ~fast_in;

  // ---------------- multiplier (single cycle, from captured operands) ----
  logic        a_sx;
  logic        b_sx;
  logic [63:0] a_wide;
  logic [63:0] b_wide;
  logic [63:0] product;
  logic [31:0] mul_res;

  assign a_sx    = ((op_q == OP_MULH) | (op_q == OP_MULHSU)) & a_q[31];
  assign b_sx    = (op_q == OP_MULH) & b_q[31];
  assign a_wide  = {{32{a_sx}}, a_q};
  assign b_wide  = {{32{b_sx}}, b_q};
  // Low 64 bits of the sign-extended product are exact for every variant.
  assign product = a_wide * b_wide;
  assign mul_res = (op_q == OP_MUL) ? product[31:0] : product[63:32];

  // ---------------- divider fast path and sign fix-up ----------------
  logic [31:0] fast_res;
  logic [31:0] fix_res;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_busy;
  logic        div_last;
  logic        div_done;

  assign fast_res = (b_q == 32'd0) ? (op_q[1] ? a_q : 32'hFFFF_FFFF)
                                   : (op_q[1] ? 32'd0 : 32'h8000_0000);
  assign fix_res  = op_q[1] ? (rem_neg_q ? (32'd0 - div_rem)  : div_rem)
                            : (quo_neg_q ? (32'd0 - div_quot) : div_quot);

  mdu_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .last      (div_last),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  assign busy = (state != IDLE);

  // Control FSM with registered done/result/rd_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      rd_q      <= 5'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      rd_out    <= 5'd0;
    end else if (flush) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= funct3_e'(funct3);
            a_q       <= operand_a;
            b_q       <= operand_b;
            rd_q      <= rd_in;
            quo_neg_q <= a_neg_in ^ b_neg_in;
            rem_neg_q <= a_neg_in;
            state     <= (funct3[2] && !fast_in) ? DIV : MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          result <= op_q[2] ? fast_res : mul_res;
          rd_out <= rd_q;
          done   <= 1'b1;
          state  <= IDLE;
        end
        DIV: begin
          if (div_last) begin
            state <= FIX;
          end else if (!div_busy) begin
            state <= IDLE;  // divider lost its operation; drop without done
          end else begin
            state <= DIV;
          end
        end
        FIX: begin
          if (div_done) begin
            result <= fix_res;
            rd_out <= rd_q;
            done   <= 1'b1;
          end else begin
            done <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result = 32'd0;

  mul_div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Architectural RV32M result computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic [63:0] pu;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'd6: begin
        if (b == 32'd0) r = a;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 32'd0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Issue one op at a negedge and follow it to done. With chain set the
  // task returns in the done cycle so the caller can start back-to-back.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit chain);
    int cyc;
    logic [31:0] exp;
    int exp_lat;
    exp     = ref_model(f, a, b);
    exp_lat = ref_latency(f, a, b);
    check("busy_at_start", {31'd0, busy}, 32'd0);
    start = 1'b1; funct3 = f; operand_a = a; operand_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      check("busy_mid", {31'd0, busy}, 32'd1);
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("result", result, exp);
    check("rd_out", {27'd0, rd_out}, {27'd0, rd});
    check("busy_on_done", {31'd0, busy}, 32'd0);
    last_result = exp;
    if (!chain) begin
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
      check("result_hold", result, exp);
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0;
    operand_a = 32'd0; operand_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    do_op(3'd5, 32'd100, 32'd0, 5'd7, 1'b0);
    do_op(3'd7, 32'd100, 32'd0, 5'd8, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b0);
    do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);

    // Flush mid-divide: no done, previous result holds, then a MUL works.
    start = 1'b1; funct3 = 3'd5; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    watch_no_done("flush_no_done", 40);
    check("flush_result_hold", result, last_result);
    do_op(3'd0, 32'd5, 32'd6, 5'd13, 1'b0);

    // Flush together with start: not accepted.
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    watch_no_done("flush_start_ignored", 5);

    // Reset at cycle 20 of a DIV.
    start = 1'b1; funct3 = 3'd4; operand_a = 32'd12345; operand_b = 32'd7; rd_in = 5'd14;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_rd_out", {27'd0, rd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_done("arst_no_stray_done", 40);

    // Back-to-back: DIV started in the MUL's done cycle.
    do_op(3'd0, 32'd123, 32'd456, 5'd15, 1'b1);
    do_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd16, 1'b0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int sel;
      f   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      do_op(f, a, b, 5'($urandom), (sel == 3));
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
